iterative_intt: RTL

- Sequential inverse NTT, the decode side of the forward NTT: takes N transformed coefficients and returns the N time-domain values mod q.
- Datapath is one shared butterfly, Cooley-Tukey decimation-in-time.
- Bit-reversed load, LOGN butterfly stages using inverse twiddles, then a final scale by N^-1 mod q.
- Sits after pointwise multiplication in the polynomial-multiply path, driven by a start/done handshake.

---
 rtl/iterative_intt.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/iterative_intt.sv
// Sequential inverse NTT built around one shared Cooley-Tukey butterfly.
// Flow: IDLE -> LOAD (bit-reversed capture, reduce mod q) -> BFLY (LOGN*N/2
// butterflies using inverse twiddles) -> SCALE (multiply by N^-1) -> DONE.
// Optional build macro INTT_SCALE_BYPASS_EN: drops the SCALE pass so BFLY
// goes straight to DONE and the unscaled (N times) result is delivered.
module iterative_intt #(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int LOGN = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N*W-1:0]       coef_in,
  input  logic [(N/2)*W-1:0]   omegas_inv,
  input  logic [W-1:0]         mod,
  input  logic [W-1:0]         n_inv,
  output logic                 busy,
  output logic                 done,
  output logic [N*W-1:0]       data_out
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StBfly,
    StScale,
    StDone
  } state_t;

  localparam logic [LOGN-1:0] LastStage = LOGN'(LOGN - 1);
  localparam logic [LOGN-2:0] LastBfly  = (LOGN-1)'(N/2 - 1);
  localparam logic [LOGN-1:0] LastIdx   = LOGN'(N - 1);

  state_t               r_state;
  logic [LOGN-1:0]      r_stage;
  logic [LOGN-2:0]      r_bfly;
  logic [LOGN-1:0]      r_idx;
  logic [W-1:0]         r_q;
  logic [W-1:0]         r_nInv;
  logic [(N/2)*W-1:0]   r_omegas;
  logic [W-1:0]         r_work [N];
  logic                 r_busy;
  logic                 r_done;
  logic [N*W-1:0]       r_dataOut;

  logic [LOGN-1:0]      w_half;
  logic [LOGN-1:0]      w_pos;
  logic [LOGN-1:0]      w_top;
  logic [LOGN-1:0]      w_bot;
  logic [LOGN-1:0]      w_twFull;
  logic [LOGN-2:0]      w_twIdx;
  logic [W-1:0]         w_tw;
  logic [W-1:0]         w_mulA;
  logic [W-1:0]         w_mulB;
  logic [2*W-1:0]       w_prod;
  logic [W-1:0]         w_t;
  logic [W-1:0]         w_u;
  logic [W:0]           w_sum;
  logic [W:0]           w_diff;
  logic [W-1:0]         w_newTop;
  logic [W-1:0]         w_newBot;
  logic [W-1:0]         w_workNext [N];

  // Reverse the bit order of an index so the load lands in DIT order.
  function automatic logic [LOGN-1:0] bitRev(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    for (int k = 0; k < LOGN; k++) r[k] = x[LOGN-1-k];
    return r;
  endfunction

  // Butterfly addressing: span doubles each stage, twiddle stride halves.
  assign w_half   = LOGN'(1) << r_stage;
  assign w_pos    = {1'b0, r_bfly} & (w_half - 1'b1);
  assign w_top    = (({1'b0, r_bfly} >> r_stage) << (r_stage + 1'b1)) | w_pos;
  assign w_bot    = w_top + w_half;
  assign w_twFull = w_pos << (LastStage - r_stage);
  assign w_twIdx  = w_twFull[LOGN-2:0];
  assign w_tw     = r_omegas[w_twIdx*W +: W];

  // One modular multiplier shared by the butterfly and the final scale.
  assign w_mulA = (r_state == StScale) ? r_work[r_idx] : r_work[w_bot];
  assign w_mulB = (r_state == StScale) ? r_nInv : w_tw;
  assign w_prod = {{W{1'b0}}, w_mulA} * {{W{1'b0}}, w_mulB};
  assign w_t    = W'(w_prod % {{W{1'b0}}, r_q});

  // Add / subtract halves with a single conditional correction back below q.
  assign w_u      = r_work[w_top];
  assign w_sum    = {1'b0, w_u} + {1'b0, w_t};
  assign w_diff   = {1'b0, w_u} + {1'b0, r_q} - {1'b0, w_t};
  assign w_newTop = (w_sum  >= {1'b0, r_q}) ? W'(w_sum  - {1'b0, r_q}) : w_sum[W-1:0];
  assign w_newBot = (w_diff >= {1'b0, r_q}) ? W'(w_diff - {1'b0, r_q}) : w_diff[W-1:0];

  // Next contents of the working RAM for whichever phase is active.
  always_comb begin
    w_workNext = r_work;
    case (r_state)
      StIdle: begin
        if (start) begin
          for (int i = 0; i < N; i++) w_workNext[bitRev(LOGN'(i))] = coef_in[i*W +: W];
        end
      end
      StLoad: begin
        for (int i = 0; i < N; i++) w_workNext[i] = r_work[i] % r_q;
      end
      StBfly: begin
        w_workNext[w_top] = w_newTop;
        w_workNext[w_bot] = w_newBot;
      end
      StScale: begin
        w_workNext[r_idx] = w_t;
      end
      default: ;
    endcase
  end

  // Control FSM with registered handshake, operand capture and result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_stage   <= '0;
      r_bfly    <= '0;
      r_idx     <= '0;
      r_q       <= '0;
      r_nInv    <= '0;
      r_omegas  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dataOut <= '0;
      for (int i = 0; i < N; i++) r_work[i] <= '0;
    end else begin
      r_work <= w_workNext;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_q      <= mod;
            r_nInv   <= n_inv;
            r_omegas <= omegas_inv;
            r_busy   <= 1'b1;
            r_state  <= StLoad;
          end
        end
        StLoad: begin
          r_stage <= '0;
          r_bfly  <= '0;
          r_state <= StBfly;
        end
        StBfly: begin
          if (r_bfly == LastBfly) begin
            r_bfly <= '0;
            if (r_stage == LastStage) begin
`ifdef INTT_SCALE_BYPASS_EN
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              for (int i = 0; i < N; i++) r_dataOut[i*W +: W] <= w_workNext[i];
              r_state <= StDone;
`else
              r_idx   <= '0;
              r_state <= StScale;
`endif
            end else begin
              r_stage <= r_stage + 1'b1;
            end
          end else begin
            r_bfly <= r_bfly + 1'b1;
          end
        end
        StScale: begin
          if (r_idx == LastIdx) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            for (int i = 0; i < N; i++) r_dataOut[i*W +: W] <= w_workNext[i];
            r_state <= StDone;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_dataOut;

endmodule
